// File: rtl/ahb_sram_slave.sv
// AHB3-Lite responder backed by a word-organised SRAM array.
// Fixed wait states, a two-cycle ERROR response and a 7-bit checksum on read data.
module ahb_sram_slave #(
   parameter int unsigned MEM_SIZE    = 4096,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic        s_hsel_i,
   input  logic [31:0] s_haddr_i,
   input  logic [1:0]  s_htrans_i,
   input  logic        s_hwrite_i,
   input  logic [2:0]  s_hsize_i,
   input  logic [31:0] s_hwdata_i,
   output logic [31:0] s_hrdata_o,
   output logic        s_hreadyout_o,
   output logic        s_hresp_o,
   output logic [6:0]  s_hrchecksum_o
);

   localparam int unsigned AW        = $clog2(MEM_SIZE);
   localparam int unsigned WORDS     = MEM_SIZE / 4;
   localparam logic [1:0]  WAIT_INIT = 2'(WAIT_STATES);

   typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

   state_e        state_q, state_d;
   logic [1:0]    wait_cnt_q, wait_cnt_d;

   logic          accept;
   logic          addr_err;
   logic          complete;
   logic          pend_q;
   logic          pend_write_q;
   logic [1:0]    pend_size_q;
   logic [AW-1:0] pend_addr_q;
   logic [AW-3:0] word_idx;
   logic [3:0]    byte_en;
   logic [31:0]   mem [WORDS];

   logic          unused_bits;
   assign unused_bits = ^{s_haddr_i[31:AW], s_htrans_i[0]};

   assign accept   = s_hsel_i & s_htrans_i[1] & s_hreadyout_o;
   assign addr_err = (s_hsize_i > 3'd2)
                   | ((s_hsize_i == 3'd1) & s_haddr_i[0])
                   | ((s_hsize_i == 3'd2) & (s_haddr_i[1:0] != 2'b00));
   // A legal data phase completes on any cycle the slave reports ready.
   assign complete = s_hreadyout_o & pend_q;
   assign word_idx = pend_addr_q[AW-1:2];

   // State register
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q    <= StIdle;
         wait_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StIdle, StErr2: begin
            state_d = StIdle;
            if (accept) begin
               if (addr_err) begin
                  state_d = StErr1;
               end else if (WAIT_STATES > 0) begin
                  state_d    = StWait;
                  wait_cnt_d = WAIT_INIT;
               end
            end
         end
         StWait: begin
            wait_cnt_d = wait_cnt_q - 2'd1;
            if (wait_cnt_q == 2'd1) state_d = StIdle;
         end
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      s_hreadyout_o = 1'b1;
      s_hresp_o     = 1'b0;
      unique case (state_q)
         StWait: s_hreadyout_o = 1'b0;
         StErr1: begin
            s_hreadyout_o = 1'b0;
            s_hresp_o     = 1'b1;
         end
         StErr2: s_hresp_o = 1'b1;
         default: begin
            s_hreadyout_o = 1'b1;
            s_hresp_o     = 1'b0;
         end
      endcase
   end

   // Erroneous transfers never become pending, so they cannot reach the array.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         pend_q       <= 1'b0;
         pend_write_q <= 1'b0;
         pend_size_q  <= 2'd0;
         pend_addr_q  <= '0;
      end else if (accept) begin
         pend_q       <= ~addr_err;
         pend_write_q <= s_hwrite_i;
         pend_size_q  <= s_hsize_i[1:0];
         pend_addr_q  <= s_haddr_i[AW-1:0];
      end else if (complete) begin
         pend_q       <= 1'b0;
      end
   end

   always_comb begin
      unique case (pend_size_q)
         2'd0:    byte_en = 4'b0001 << pend_addr_q[1:0];
         2'd1:    byte_en = pend_addr_q[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   always_ff @(posedge s_clk_i) begin
      if (complete && pend_write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= s_hwdata_i[8*b +: 8];
         end
      end
   end

   assign s_hrdata_o = (pend_q && !pend_write_q) ? mem[word_idx] : 32'h0;

   always_comb begin
      s_hrchecksum_o = 7'h0;
      for (int j = 0; j < 32; j++) begin
         s_hrchecksum_o[j % 7] = s_hrchecksum_o[j % 7] ^ s_hrdata_o[j];
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states) driven by a pipelined
// AHB master and checked against a byte-addressed reference memory.
module tb_ahb_sram_slave;

   localparam int unsigned MEM_SIZE = 4096;
   localparam int          MAXT     = 32;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn   [2];
   logic        hsel   [2];
   logic [31:0] haddr  [2];
   logic [1:0]  htrans [2];
   logic        hwrite [2];
   logic [2:0]  hsize  [2];
   logic [31:0] hwdata [2];
   logic [31:0] hrdata [2];
   logic        hready [2];
   logic        hresp  [2];
   logic [6:0]  hcs    [2];

   ahb_sram_slave #(.MEM_SIZE(MEM_SIZE), .WAIT_STATES(0)) u_dut0 (
      .s_clk_i        (clk),
      .s_resetn_i     (rstn[0]),
      .s_hsel_i       (hsel[0]),
      .s_haddr_i      (haddr[0]),
      .s_htrans_i     (htrans[0]),
      .s_hwrite_i     (hwrite[0]),
      .s_hsize_i      (hsize[0]),
      .s_hwdata_i     (hwdata[0]),
      .s_hrdata_o     (hrdata[0]),
      .s_hreadyout_o  (hready[0]),
      .s_hresp_o      (hresp[0]),
      .s_hrchecksum_o (hcs[0])
   );

   ahb_sram_slave #(.MEM_SIZE(MEM_SIZE), .WAIT_STATES(2)) u_dut2 (
      .s_clk_i        (clk),
      .s_resetn_i     (rstn[1]),
      .s_hsel_i       (hsel[1]),
      .s_haddr_i      (haddr[1]),
      .s_htrans_i     (htrans[1]),
      .s_hwrite_i     (hwrite[1]),
      .s_hsize_i      (hsize[1]),
      .s_hwdata_i     (hwdata[1]),
      .s_hrdata_o     (hrdata[1]),
      .s_hreadyout_o  (hready[1]),
      .s_hresp_o      (hresp[1]),
      .s_hrchecksum_o (hcs[1])
   );

   int          n_checks = 0;
   int          n_fail   = 0;

   // Transfer list for one run and what the master observed for each.
   logic        t_wr    [MAXT];
   logic [2:0]  t_size  [MAXT];
   logic [31:0] t_addr  [MAXT];
   logic [31:0] t_wdata [MAXT];
   logic [31:0] r_rdata [MAXT];
   logic        r_resp  [MAXT];
   logic        r_resp1 [MAXT];
   logic [6:0]  r_cs    [MAXT];
   int          r_len   [MAXT];
   int          n_t;
   int          run_cycles;

   logic [7:0]  rm [int];
   logic [31:0] wd [8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_err(input logic [2:0] s, input logic [31:0] a);
      return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
   endfunction

   // Checksum as a fold of 7-bit slices: bit k collects every data bit j with j mod 7 == k.
   function automatic logic [6:0] fold(input logic [31:0] v);
      logic [34:0] x;
      x = {3'b000, v};
      return x[6:0] ^ x[13:7] ^ x[20:14] ^ x[27:21] ^ x[34:28];
   endfunction

   task automatic add(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata);
      t_wr[n_t]    = wr;
      t_size[n_t]  = size;
      t_addr[n_t]  = addr;
      t_wdata[n_t] = wdata;
      n_t++;
   endtask

   // Pipelined master: next address phase overlaps the current data phase and is held
   // while the slave is not ready. Called at posedge+1.
   task automatic run(input int d);
      int ap, dp, len;
      bit done;
      ap = 0; dp = -1; len = 0; done = 1'b0; run_cycles = 0;
      for (int budget = 0; budget < 200 && !done; budget++) begin
         if (ap < n_t) begin
            hsel[d]   = 1'b1;
            htrans[d] = (ap == 0) ? 2'd2 : 2'd3;
            haddr[d]  = t_addr[ap];
            hwrite[d] = t_wr[ap];
            hsize[d]  = t_size[ap];
         end else begin
            hsel[d]   = 1'b0;
            htrans[d] = 2'd0;
         end
         hwdata[d] = (dp >= 0) ? t_wdata[dp] : 32'h0;
         if (dp >= 0) begin
            len++;
            if (len == 1) r_resp1[dp] = hresp[d];
         end
         if (hready[d]) begin
            if (dp >= 0) begin
               r_rdata[dp] = hrdata[d];
               r_resp[dp]  = hresp[d];
               r_cs[dp]    = hcs[d];
               r_len[dp]   = len;
            end
            if (ap < n_t) begin
               dp = ap;
               ap++;
               len = 0;
            end else begin
               dp = -1;
            end
            if (dp < 0 && ap >= n_t) done = 1'b1;
         end
         @(posedge clk); #1;
         run_cycles++;
      end
      hsel[d]   = 1'b0;
      htrans[d] = 2'd0;
      check($sformatf("d%0d_run_done", d), 32'(done), 32'd1);
   endtask

   // Replay the run's transfers through the reference memory and compare.
   task automatic verify(input int d);
      int          ws;
      int unsigned a, base;
      logic [31:0] exp;
      ws = (d == 0) ? 0 : 2;
      for (int i = 0; i < n_t; i++) begin
         a    = t_addr[i] % MEM_SIZE;
         base = d * MEM_SIZE;
         if (is_err(t_size[i], t_addr[i])) begin
            check($sformatf("d%0d_t%0d_err_len", d, i), 32'(r_len[i]), 32'd2);
            check($sformatf("d%0d_t%0d_err_resp1", d, i), 32'(r_resp1[i]), 32'd1);
            check($sformatf("d%0d_t%0d_err_resp2", d, i), 32'(r_resp[i]), 32'd1);
            check($sformatf("d%0d_t%0d_err_rdata", d, i), r_rdata[i], 32'h0);
         end else begin
            check($sformatf("d%0d_t%0d_len", d, i), 32'(r_len[i]), 32'(1 + ws));
            check($sformatf("d%0d_t%0d_resp1", d, i), 32'(r_resp1[i]), 32'd0);
            check($sformatf("d%0d_t%0d_resp", d, i), 32'(r_resp[i]), 32'd0);
            if (t_wr[i]) begin
               for (int k = 0; k < (1 << t_size[i]); k++) begin
                  rm[int'(base + a + k)] = t_wdata[i][8*((a + k) % 4) +: 8];
               end
               check($sformatf("d%0d_t%0d_wr_rdata", d, i), r_rdata[i], 32'h0);
            end else begin
               for (int k = 0; k < 4; k++) exp[8*k +: 8] = rm[int'(base + (a & ~32'd3) + k)];
               check($sformatf("d%0d_t%0d_rdata", d, i), r_rdata[i], exp);
               check($sformatf("d%0d_t%0d_cs", d, i), 32'(r_cs[i]), 32'(fold(exp)));
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rstn[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = 2'd0;
         hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = 32'h0;
      end
      @(posedge clk); @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_rst_hready", d), 32'(hready[d]), 32'd1);
         check($sformatf("d%0d_rst_hresp", d), 32'(hresp[d]), 32'd0);
         check($sformatf("d%0d_rst_hrdata", d), hrdata[d], 32'h0);
         check($sformatf("d%0d_rst_cs", d), 32'(hcs[d]), 32'd0);
         rstn[d] = 1'b1;
      end
      @(posedge clk); #1;

      // Back-to-back write then read
      n_t = 0;
      add(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      add(1'b0, 3'd2, 32'h10, 32'h0);
      run(0); verify(0);
      check("b2b_rdata", r_rdata[1], 32'hDEADBEEF);

      // Byte-lane writes
      n_t = 0;
      add(1'b1, 3'd2, 32'h20, 32'h11223344);
      add(1'b1, 3'd0, 32'h23, 32'hAA000000);
      add(1'b1, 3'd1, 32'h20, 32'h0000BBCC);
      add(1'b0, 3'd2, 32'h20, 32'h0);
      run(0); verify(0);
      check("lanes_rdata", r_rdata[3], 32'hAA22BBCC);

      // Error responses leave the array untouched
      n_t = 0;
      add(1'b1, 3'd1, 32'h21, 32'hFFFFFFFF);
      add(1'b0, 3'd3, 32'h20, 32'h0);
      add(1'b1, 3'd3, 32'h20, 32'hFFFFFFFF);
      add(1'b0, 3'd2, 32'h20, 32'h0);
      run(0); verify(0);
      check("err_untouched", r_rdata[3], 32'hAA22BBCC);

      // Two wait states, with next address held during the wait
      n_t = 0;
      add(1'b1, 3'd2, 32'h30, 32'h12345678);
      add(1'b0, 3'd2, 32'h30, 32'h0);
      add(1'b1, 3'd1, 32'h33, 32'hFFFFFFFF);
      add(1'b0, 3'd0, 32'h31, 32'h0);
      run(1); verify(1);
      check("ws2_read_len", 32'(r_len[1]), 32'd3);
      check("ws2_byte_read_full_word", r_rdata[3], 32'h12345678);

      // Streamed reads of 8 consecutive words
      n_t = 0;
      for (int i = 0; i < 8; i++) begin
         wd[i] = $urandom;
         add(1'b1, 3'd2, 32'h100 + 32'(4 * i), wd[i]);
      end
      run(0); verify(0);
      n_t = 0;
      for (int i = 0; i < 8; i++) add(1'b0, 3'd2, 32'h100 + 32'(4 * i), 32'h0);
      run(0); verify(0);
      check("stream_cycles", 32'(run_cycles), 32'd9);
      for (int i = 0; i < 8; i++) check($sformatf("stream_w%0d", i), r_rdata[i], wd[i]);

      // Random mix on both instances over a pre-written region
      for (int d = 0; d < 2; d++) begin
         n_t = 0;
         for (int i = 0; i < 16; i++) add(1'b1, 3'd2, 32'h200 + 32'(4 * i), $urandom);
         run(d); verify(d);
         n_t = 0;
         for (int i = 0; i < 14; i++) begin
            add(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                32'h200 + 32'($urandom_range(0, 63)), $urandom);
         end
         add(1'b0, 3'd2, 32'h200, 32'h0);
         run(d); verify(d);
      end

      // Reset during the wait states of a write discards it
      n_t = 0;
      add(1'b1, 3'd2, 32'h40, 32'h0BADF00D);
      run(1); verify(1);
      hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = 32'h40; hwrite[1] = 1'b1; hsize[1] = 3'd2;
      @(posedge clk); #1;
      hsel[1] = 1'b0; htrans[1] = 2'd0; hwdata[1] = 32'hFFFFFFFF;
      check("rst_mid_hready_before", 32'(hready[1]), 32'd0);
      #2 rstn[1] = 1'b0;
      #1;
      check("rst_mid_hready", 32'(hready[1]), 32'd1);
      check("rst_mid_hresp", 32'(hresp[1]), 32'd0);
      check("rst_mid_hrdata", hrdata[1], 32'h0);
      check("rst_mid_cs", 32'(hcs[1]), 32'd0);
      @(posedge clk); #1;
      rstn[1] = 1'b1;
      @(posedge clk); #1;
      n_t = 0;
      add(1'b0, 3'd2, 32'h40, 32'h0);
      run(1); verify(1);
      check("rst_mid_unchanged", r_rdata[0], 32'h0BADF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
